// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative radix-2 multiply/divide engine producing the {HI,LO} results for
// MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU. It feeds the HI/LO register block
// directly and reads that block back on HLin for the accumulate operations.
//
// Ports:
//   Clk     - clock, all state changes on the rising edge
//   Reset   - synchronous active-high reset, aborts any operation in flight
//   Start   - request strobe, only looked at while idle
//   Op      - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//             100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU
//   A, B    - rs / rt operands
//   HLin    - current {HI,LO}, accumulate ops only
//   Busy    - high while an operation is in progress (state not IDLE)
//   Done    - one-cycle pulse while the result is presented
//   HIout   - result high word (remainder for divides)
//   LOout   - result low word (quotient for divides)
//   HWrite  - HI write enable, same as Done
//   LWrite  - LO write enable, same as Done
//
// Timing: Start seen at edge k, 32 iterations on edges k+1..k+32, Done high
// during the following cycle, back to IDLE at edge k+33.

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [2:0]         Op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2*WIDTH-1:0] HLin,
    output logic               Busy,
    output logic               Done,
    output logic [WIDTH-1:0]   HIout,
    output logic [WIDTH-1:0]   LOout,
    output logic               HWrite,
    output logic               LWrite
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [4:0]         count_reg;
    logic [2:0]         op_reg;
    logic               neg_res_reg;   // product / quotient sign
    logic               neg_a_reg;     // remainder sign follows the dividend

    // Multiply datapath: multiplicand shifts left, multiplier shifts right.
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] prod_reg;

    // Divide datapath: 33-bit partial remainder, dividend bits shifted out of
    // quo_reg MSB-first while quotient bits enter at the LSB.
    logic [WIDTH:0]     rem_reg;
    logic [WIDTH-1:0]   quo_reg;
    logic [WIDTH-1:0]   divisor_reg;

    logic [2*WIDTH-1:0] hl_reg;

    // Operand preparation while idle
    logic               is_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign is_signed = ~Op[0];
    assign a_neg     = is_signed & A[WIDTH-1];
    assign b_neg     = is_signed & B[WIDTH-1];
    assign a_mag     = a_neg ? (~A + 1'b1) : A;
    assign b_mag     = b_neg ? (~B + 1'b1) : B;

    // One iteration of each datapath
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH:0]     rem_shift;
    logic               rem_fits;
    logic [WIDTH:0]     rem_step;
    logic [WIDTH-1:0]   quo_step;

    always_comb begin
        prod_step = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
        rem_shift = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
        rem_fits  = (rem_shift >= {1'b0, divisor_reg});
        rem_step  = rem_fits ? (rem_shift - {1'b0, divisor_reg}) : rem_shift;
        quo_step  = {quo_reg[WIDTH-2:0], rem_fits};
    end

    // Sign correction and accumulation, used on the final iteration
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH-1:0]   rem_signed;
    logic [WIDTH-1:0]   res_hi, res_lo;

    always_comb begin
        prod_signed = neg_res_reg ? (~prod_step + 1'b1) : prod_step;
        quo_signed  = neg_res_reg ? (~quo_step + 1'b1) : quo_step;
        rem_signed  = neg_a_reg ? (~rem_step[WIDTH-1:0] + 1'b1) : rem_step[WIDTH-1:0];
        res_hi      = prod_signed[2*WIDTH-1:WIDTH];
        res_lo      = prod_signed[WIDTH-1:0];
        case (op_reg[2:1])
            2'b01: begin
                // Divide by zero: the restoring loop leaves |A| as remainder,
                // so HI already equals A; only the quotient needs forcing.
                res_hi = rem_signed;
                res_lo = (divisor_reg == '0) ? '1 : quo_signed;
            end
            2'b10: {res_hi, res_lo} = hl_reg + prod_signed;
            2'b11: {res_hi, res_lo} = hl_reg - prod_signed;
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (Start) state_next = CALC;
            CALC:    if (count_reg == 5'd31) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            HIout     <= '0;
            LOout     <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        op_reg      <= Op;
                        neg_res_reg <= a_neg ^ b_neg;
                        neg_a_reg   <= a_neg;
                        mcand_reg   <= {{WIDTH{1'b0}}, a_mag};
                        mplier_reg  <= b_mag;
                        prod_reg    <= '0;
                        rem_reg     <= '0;
                        quo_reg     <= a_mag;
                        divisor_reg <= b_mag;
                        hl_reg      <= Op[2] ? HLin : '0;
                        count_reg   <= '0;
                    end
                end
                CALC: begin
                    mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
                    mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
                    prod_reg   <= prod_step;
                    rem_reg    <= rem_step;
                    quo_reg    <= quo_step;
                    count_reg  <= count_reg + 5'd1;
                    if (count_reg == 5'd31) begin
                        HIout <= res_hi;
                        LOout <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy   = (state_reg != IDLE);
    assign Done   = (state_reg == DONE);
    assign HWrite = Done;
    assign LWrite = Done;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    logic        Clk = 1'b0;
    logic        Reset, Start;
    logic [2:0]  Op;
    logic [31:0] A, B;
    logic [63:0] HLin;
    logic        Busy, Done, HWrite, LWrite;
    logic [31:0] HIout, LOout;

    int checks   = 0;
    int failures = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .HLin(HLin), .Busy(Busy), .Done(Done), .HIout(HIout), .LOout(LOout),
        .HWrite(HWrite), .LWrite(LWrite)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference result {HI,LO} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      q, r;
        logic [63:0] p;
        if (op[2:1] == 2'b01) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (op[0]) return {a % b, a / b};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        if (op[0]) p = {32'd0, a} * {32'd0, b};
        else       p = sa * sb;
        case (op[2:1])
            2'b10:   return hl + p;
            2'b11:   return hl - p;
            default: return p;
        endcase
    endfunction

    // Timing model: a countdown of remaining busy cycles.
    int          remaining = 0;
    logic [63:0] pending, exp_hl;
    bit          model_valid = 0;

    always @(posedge Clk) begin
        if (Reset) begin
            remaining   = 0;
            exp_hl      = 64'd0;
            model_valid = 1;
        end else if (remaining == 0) begin
            if (Start) begin
                remaining = 33;
                pending   = model(Op, A, B, HLin);
            end
        end else begin
            remaining--;
            if (remaining == 1) exp_hl = pending;
        end
    end

    always @(negedge Clk) begin
        if (model_valid) begin
            chk("cmp_busy",   64'(Busy),   64'(remaining != 0));
            chk("cmp_done",   64'(Done),   64'(remaining == 1));
            chk("cmp_hwrite", 64'(HWrite), 64'(remaining == 1));
            chk("cmp_lwrite", 64'(LWrite), 64'(remaining == 1));
            chk("cmp_hiout",  64'(HIout),  64'(exp_hl[63:32]));
            chk("cmp_loout",  64'(LOout),  64'(exp_hl[31:0]));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Issue one operation, wait for Done, check latency/Busy and optionally
    // literal results. glitch_at >= 0 raises Start again during CALC.
    task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] hl, input bit lit,
                         input logic [31:0] ehi, input logic [31:0] elo, input int glitch_at);
        int n = 0;
        int busy_cnt = 0;
        Start = 1'b1; Op = op; A = a; B = b; HLin = hl;
        tick();
        Start = 1'b0;
        A = $urandom; B = $urandom; HLin = {$urandom, $urandom}; Op = 3'($urandom_range(0, 7));
        while (Done !== 1'b1 && n < 40) begin
            if (Busy === 1'b1) busy_cnt++;
            Start = (n == glitch_at);
            tick();
            n++;
        end
        Start = 1'b0;
        if (Busy === 1'b1) busy_cnt++;
        chk({nm, "_latency"}, 64'(n), 64'd32);
        chk({nm, "_hwrite"}, 64'({HWrite, LWrite}), 64'd3);
        if (lit) begin
            chk({nm, "_hi"}, 64'(HIout), 64'(ehi));
            chk({nm, "_lo"}, 64'(LOout), 64'(elo));
        end
        tick();
        chk({nm, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        chk({nm, "_idle_after"}, 64'({Busy, Done}), 64'd0);
        $display("op %s: op=%b a=%h b=%h hl=%h -> hi=%h lo=%h", nm, op, a, b, hl, HIout, LOout);
    endtask

    initial begin
        int done_cnt;
        Reset = 1'b1; Start = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0; HLin = 64'd0;
        tick(); tick();
        Reset = 1'b0;
        chk("reset_busy", 64'(Busy), 64'd0);
        chk("reset_done", 64'({Done, HWrite, LWrite}), 64'd0);
        chk("reset_hilo", {HIout, LOout}, 64'd0);
        tick();

        do_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1, 32'hFFFF_FFFE, 32'h0000_0001, -1);
        do_op("mult_neg",  3'b000, 32'hFFFF_FFFD, 32'd7,         64'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1);
        do_op("mult_min",  3'b000, 32'h8000_0000, 32'h8000_0000, 64'd0, 1, 32'h4000_0000, 32'h0000_0000, -1);
        do_op("div_neg",   3'b010, 32'hFFFF_FFF9, 32'd2,         64'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
        do_op("divu",      3'b011, 32'd100,       32'd7,         64'd0, 1, 32'd2,         32'd14,        -1);
        do_op("div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 1, 32'h0000_0000, 32'h8000_0000, -1);
        do_op("divu_zero", 3'b011, 32'h1234_5678, 32'd0,         64'd0, 1, 32'h1234_5678, 32'hFFFF_FFFF, -1);
        do_op("div_zero",  3'b010, 32'hFFFF_FF00, 32'd0,         64'd0, 1, 32'hFFFF_FF00, 32'hFFFF_FFFF, -1);
        do_op("madd",      3'b100, 32'd2,         32'd3,         64'h0000_0000_FFFF_FFFF, 1, 32'h0000_0001, 32'h0000_0005, -1);
        do_op("msubu",     3'b111, 32'd1,         32'd1,         64'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        do_op("msub",      3'b110, 32'hFFFF_FFFE, 32'd3,         64'd10, 1, 32'h0000_0000, 32'h0000_0010, -1);
        do_op("maddu",     3'b101, 32'hFFFF_FFFF, 32'd2,         64'd0, 1, 32'h0000_0001, 32'hFFFF_FFFE, -1);
        do_op("start_ign", 3'b001, 32'h0001_0000, 32'h0001_0000, 64'd0, 1, 32'h0000_0001, 32'h0000_0000, 10);

        // Abort in the middle of CALC
        Start = 1'b1; Op = 3'b001; A = 32'h0000_1234; B = 32'h0000_5678; HLin = 64'd0;
        tick();
        Start = 1'b0;
        repeat (20) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_hilo", {HIout, LOout}, 64'd0);
        done_cnt = 0;
        repeat (40) begin
            if (HWrite === 1'b1 || LWrite === 1'b1 || Done === 1'b1) done_cnt++;
            tick();
        end
        chk("abort_no_write", 64'(done_cnt), 64'd0);
        $display("op abort: reset during CALC, busy=%b hi=%h lo=%h", Busy, HIout, LOout);

        do_op("after_abort", 3'b011, 32'd100, 32'd7, 64'd0, 1, 32'd2, 32'd14, -1);

        for (int i = 0; i < 16; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra, rb;
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (i % 4 == 0) rb = 32'hFFFF_FFFF;
            do_op("random", rop, ra, rb, {$urandom, $urandom}, 0, 32'd0, 32'd0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
